// File: rtl/data_mem_resp_pkg.sv
// rtl/data_mem_resp_pkg.sv - shared definitions for the data memory response block
//
// Purpose: FSM state encoding, default LATENCY / DEPTH_WORDS values and
// err_sticky bit positions shared by data_mem_resp and its array.
// Ports: none (package).
package data_mem_resp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_LATENCY     = 2;
  localparam int DEF_DEPTH_WORDS = 256;

  localparam int ERR_MISALIGN_BIT = 0;
  localparam int ERR_COLLIDE_BIT  = 1;

endpackage

// File: rtl/data_mem_resp_array.sv
// rtl/data_mem_resp_array.sv - single-port word array, synchronous write, asynchronous read
//
// Purpose: backing store for data_mem_resp. Contents are not reset.
// Ports:
//   clk    - clock, write occurs on rising edge
//   we     - write enable
//   idx    - word index (shared by read and write)
//   wdata  - write data
//   rdata  - combinational read data of mem[idx]
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - fixed-latency data memory with stall, alignment and collision errors
//
// Purpose: holds each aligned request for LATENCY cycles (stall high for the
// first LATENCY-1) and performs the access in the completion cycle.
// Misaligned requests are rejected immediately; errors are recorded sticky.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   mem_read    - read request
//   mem_write   - write request (wins when both are high)
//   addr        - byte address; word index wraps modulo DEPTH_WORDS
//   wdata       - store data
//   rdata       - load data, nonzero only in a read's completion cycle
//   stall       - request pending, pipeline must hold EX/MEM
//   err_align   - misaligned request rejected this cycle
//   err_sticky  - bit0 misaligned seen, bit1 read+write collision seen
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err_align,
  output logic [1:0]  err_sticky
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state, state_n;
  logic [3:0]  wcnt, wcnt_n;
  logic        req, misaligned, complete;
  logic [AW-1:0] idx;
  logic [31:0] arr_rdata;
  logic        unused_addr;

  assign req        = mem_read | mem_write;
  assign misaligned = req & (addr[1:0] != 2'b00);
  assign idx        = addr[AW+1:2];
  // High address bits intentionally do not participate in decoding.
  assign unused_addr = ^addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    stall     = 1'b0;
    err_align = 1'b0;
    complete  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (misaligned) begin
            err_align = 1'b1;
          end else if (req) begin
            if (LATENCY == 1) begin
              complete = 1'b1;
            end else begin
              stall   = 1'b1;
              state_n = BUSY;
              wcnt_n  = 4'(LATENCY - 2);
            end
          end
        end
        BUSY: begin
          if (!req) begin
            // Requester withdrew: abandon the access without touching the array.
            state_n = IDLE;
            wcnt_n  = 4'd0;
          end else if (misaligned) begin
            // Address went misaligned under a held request: reject, never stall.
            err_align = 1'b1;
            state_n   = IDLE;
            wcnt_n    = 4'd0;
          end else if (wcnt != 4'd0) begin
            stall  = 1'b1;
            wcnt_n = wcnt - 4'd1;
          end else begin
            complete = 1'b1;
            state_n  = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          wcnt_n  = 4'd0;
        end
      endcase
    end
  end

  // A read+write collision is performed as a write, so it returns no load data.
  assign rdata = (complete && mem_read && !mem_write) ? arr_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= 2'b00;
    end else begin
      if (err_align) begin
        err_sticky[ERR_MISALIGN_BIT] <= 1'b1;
      end
      if (complete && mem_read && mem_write) begin
        err_sticky[ERR_COLLIDE_BIT] <= 1'b1;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (complete & mem_write),
    .idx   (idx),
    .wdata (wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - self-checking bench for data_mem_resp at LATENCY 1, 2 and 4
module tb_data_mem_resp;

  localparam int DEPTH = 256;
  localparam int NINST = 3;

  logic        clk;
  logic        reset;
  logic        mr [NINST];
  logic        mw [NINST];
  logic [31:0] ad [NINST];
  logic [31:0] wd [NINST];
  logic [31:0] rd [NINST];
  logic        st [NINST];
  logic        ea [NINST];
  logic [1:0]  es [NINST];

  logic [31:0] ref_mem    [NINST][DEPTH];
  logic [1:0]  ref_sticky [NINST];

  int n_cmp;
  int n_bad;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    data_mem_resp #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mr[g]),
      .mem_write  (mw[g]),
      .addr       (ad[g]),
      .wdata      (wd[g]),
      .rdata      (rd[g]),
      .stall      (st[g]),
      .err_align  (ea[g]),
      .err_sticky (es[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request held until it completes (or one cycle if misaligned).
  // Leaves the request asserted; the next call or idle() replaces it.
  task automatic do_access(input int k, input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] d);
    int lat;
    int widx;
    lat  = lat_of(k);
    widx = int'((a >> 2) % DEPTH);
    @(negedge clk);
    mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
    if (a[1:0] != 2'b00) begin
      #1;
      check_eq($sformatf("mis_err_align[%0d]", k), {31'd0, ea[k]}, 32'd1);
      check_eq($sformatf("mis_stall[%0d]", k), {31'd0, st[k]}, 32'd0);
      check_eq($sformatf("mis_rdata[%0d]", k), rd[k], 32'd0);
      ref_sticky[k][0] = 1'b1;
    end else begin
      for (int c = 0; c < lat; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        check_eq($sformatf("stall[%0d]c%0d", k, c), {31'd0, st[k]},
                 (c < lat - 1) ? 32'd1 : 32'd0);
        check_eq($sformatf("err_align[%0d]", k), {31'd0, ea[k]}, 32'd0);
        if (c == lat - 1) begin
          check_eq($sformatf("rdata[%0d]@%h", k, a), rd[k],
                   (r && !w) ? ref_mem[k][widx] : 32'd0);
          if (w) ref_mem[k][widx] = d;
          if (r && w) ref_sticky[k][1] = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    mr[k] = 1'b0; mw[k] = 1'b0;
    #1;
    check_eq($sformatf("idle_stall[%0d]", k), {31'd0, st[k]}, 32'd0);
    check_eq($sformatf("idle_rdata[%0d]", k), rd[k], 32'd0);
    check_eq($sformatf("idle_err_align[%0d]", k), {31'd0, ea[k]}, 32'd0);
    check_eq($sformatf("sticky[%0d]", k), {30'd0, es[k]}, {30'd0, ref_sticky[k]});
  endtask

  initial begin
    int k;
    int kind;
    logic [31:0] a;
    logic [31:0] d;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    for (int i = 0; i < NINST; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = 32'd0; wd[i] = 32'd0;
      ref_sticky[i] = 2'b00;
    end
    // Requests during reset must be ignored.
    mr[0] = 1'b1; mw[1] = 1'b1; mr[2] = 1'b1; ad[2] = 32'h6;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < NINST; i++) begin
      check_eq($sformatf("rst_stall[%0d]", i), {31'd0, st[i]}, 32'd0);
      check_eq($sformatf("rst_rdata[%0d]", i), rd[i], 32'd0);
      check_eq($sformatf("rst_err_align[%0d]", i), {31'd0, ea[i]}, 32'd0);
      check_eq($sformatf("rst_sticky[%0d]", i), {30'd0, es[i]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NINST; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = 32'd0;
    end

    // Preload every word of every instance, back to back.
    for (int i = 0; i < NINST; i++) begin
      for (int w = 0; w < DEPTH; w++) begin
        do_access(i, 1'b0, 1'b1, 32'(w * 4), $urandom);
      end
      idle(i);
    end

    // LATENCY=2 write then read of 0x10.
    do_access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_access(1, 1'b1, 1'b0, 32'h10, 32'h0);
    check_eq("l2_readback", ref_mem[1][4], 32'hDEADBEEF);
    idle(1);

    // LATENCY=1 four consecutive reads.
    for (int i = 0; i < 4; i++) do_access(0, 1'b1, 1'b0, 32'(i * 4), 32'h0);
    idle(0);

    // Misaligned read of 0x6 leaves array unchanged.
    do_access(0, 1'b1, 1'b0, 32'h6, 32'h0);
    idle(0);
    check_eq("mis_sticky", {30'd0, es[0]}, 32'd1);
    do_access(0, 1'b1, 1'b0, 32'h4, 32'h0);
    idle(0);

    // Index wrap: 0x400 aliases word 0.
    do_access(1, 1'b0, 1'b1, 32'h400, 32'h12345678);
    do_access(1, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(1);

    // Read+write collision at 0x8.
    do_access(1, 1'b1, 1'b1, 32'h8, 32'h1);
    idle(1);
    check_eq("collide_sticky1", {31'd0, es[1][1]}, 32'd1);
    do_access(1, 1'b1, 1'b0, 32'h8, 32'h0);
    idle(1);

    // Request withdrawn mid-BUSY: no write.
    @(negedge clk);
    mw[2] = 1'b1; ad[2] = 32'h30; wd[2] = 32'h0BADF00D;
    #1;
    check_eq("abort_stall0", {31'd0, st[2]}, 32'd1);
    @(negedge clk);
    mw[2] = 1'b0;
    #1;
    check_eq("abort_stall1", {31'd0, st[2]}, 32'd0);
    idle(2);
    do_access(2, 1'b1, 1'b0, 32'h30, 32'h0);
    idle(2);

    // Reset in the 2nd stall cycle of a LATENCY=4 write.
    @(negedge clk);
    mw[2] = 1'b1; ad[2] = 32'h20; wd[2] = 32'hAAAA5555;
    #1;
    check_eq("rstmid_stall_a", {31'd0, st[2]}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rstmid_stall_b", {31'd0, st[2]}, 32'd0);
    check_eq("rstmid_rdata", rd[2], 32'd0);
    @(negedge clk);
    reset = 1'b0; mw[2] = 1'b0;
    for (int i = 0; i < NINST; i++) ref_sticky[i] = 2'b00;
    #1;
    check_eq("rstmid_stall_c", {31'd0, st[2]}, 32'd0);
    for (int i = 0; i < NINST; i++)
      check_eq($sformatf("rstmid_sticky[%0d]", i), {30'd0, es[i]}, 32'd0);
    do_access(2, 1'b1, 1'b0, 32'h20, 32'h0);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      k    = int'($urandom_range(0, NINST - 1));
      kind = int'($urandom_range(0, 9));
      a    = $urandom & 32'hFFFF_FFFC;
      d    = $urandom;
      case (kind)
        0:       do_access(k, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), d);
        1:       do_access(k, 1'b1, 1'b1, a, d);
        2, 3, 4: do_access(k, 1'b0, 1'b1, a, d);
        default: do_access(k, 1'b1, 1'b0, a, d);
      endcase
      if (kind == 0 || $urandom_range(0, 3) == 0) idle(k);
      else begin
        @(negedge clk);
        mr[k] = 1'b0; mw[k] = 1'b0;
      end
    end
    for (int i = 0; i < NINST; i++) idle(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the data array (power of two, 16..4096).
REQ-002 Parameter LATENCY, default 2, cycles a request is held before it completes (1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 mem_read  input  1  read request from the EX/MEM stage.
REQ-006 mem_write  input  1  write request from the EX/MEM stage.
REQ-007 addr  input  32  byte address of the access.
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  load data, valid only in the completion cycle of a read.
REQ-010 stall  output  1  high while a request is pending; the pipeline freezes EX/MEM while high.
REQ-011 err_align  output  1  high in the cycle a misaligned request is rejected.
REQ-012 err_sticky  output  2  bit0 = misaligned seen, bit1 = read+write collision seen.

Function
REQ-013 Request present SHALL mean mem_read | mem_write; index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so the index wraps modulo DEPTH_WORDS.
REQ-014 FSM states SHALL be IDLE and BUSY, with a 4-bit wait counter wcnt.
REQ-015 IDLE with no request SHALL hold stall=0 and rdata=0.
REQ-016 IDLE with an aligned request and LATENCY=1 SHALL complete in the same cycle, with stall=0 and no state change.
REQ-017 IDLE with an aligned request and LATENCY>1 SHALL drive stall=1, move to BUSY, and load wcnt=LATENCY-2.
REQ-018 In BUSY with wcnt>0, stall SHALL be 1 and wcnt SHALL decrement.
REQ-019 In BUSY with wcnt=0, the cycle SHALL be the completion cycle: stall=0, next state IDLE.
REQ-020 In a completion cycle for a read, rdata SHALL combinationally equal mem[index].
REQ-021 In a completion cycle for a write, mem[index] SHALL be updated with wdata at that clock edge.
REQ-022 Total request latency SHALL be exactly LATENCY cycles, with stall high for the first LATENCY-1 of them.
REQ-023 Address and data SHALL be sampled only in the completion cycle; the requester holds them stable while stall=1.
REQ-024 If mem_read and mem_write drop while in BUSY, the FSM SHALL return to IDLE next cycle without accessing memory.
REQ-025 If mem_read and mem_write are both high, the access SHALL be treated as a write, rdata SHALL be 0, and err_sticky[1] SHALL be set at completion.
REQ-026 A request with addr[1:0]!=0 SHALL never stall or enter BUSY.
REQ-027 A misaligned request SHALL drive err_align=1 and rdata=0 in its presence cycle, leave the array unmodified, and set err_sticky[0].
REQ-028 Back-to-back requests SHALL work as follows: a request still present in the cycle after a completion starts a new access from IDLE.

Reset
REQ-029 While reset=1: state=IDLE, wcnt=0, err_sticky=0, stall=0, rdata=0, err_align=0, regardless of mem_read and mem_write.
REQ-030 Reset asserted mid-BUSY SHALL abort the access with no array write.
REQ-031 Array contents SHALL NOT be cleared by reset.

Structure
REQ-032 A shared pipeline package SHALL hold the FSM state encoding, the LATENCY and DEPTH_WORDS defaults, and the err_sticky bit positions.
REQ-033 The array SHALL be a sub-module dmem_array: single port, synchronous write, asynchronous read.
REQ-034 The FSM, counter and error logic SHALL reside in data_mem_resp.

Verification
REQ-035 LATENCY=2: write 0xDEADBEEF to addr 0x10, then read 0x10 -> stall=1 for exactly 1 cycle per access; rdata=0xDEADBEEF in the read's completion cycle.
REQ-036 LATENCY=1: four consecutive reads of 0x0,0x4,0x8,0xC -> stall stays 0; rdata matches the preloaded values each cycle.
REQ-037 Read addr 0x6 -> err_align=1 for 1 cycle; stall=0; err_sticky=2'b01; array unchanged.
REQ-038 DEPTH_WORDS=256: write 0x12345678 to addr 0x400, then read addr 0x0 -> rdata=0x12345678 (wrap).
REQ-039 LATENCY=4: start a write to 0x20 of 0xAAAA5555 and assert reset in the 2nd stall cycle -> stall=0 next cycle; a later read of 0x20 returns the old value.
REQ-040 mem_read=mem_write=1 at addr 0x8, wdata=0x1 -> write performed; rdata=0; err_sticky[1]=1.
